// File: rtl/pc_sequencer.sv
// Program counter sequencer: increment / relative branch / absolute load with
// stall handling, a one-entry pending branch/load buffer and a sticky fault
// flag for targets outside 0..LIMIT. All outputs come straight from registers.

module pc_sequencer #(
    parameter int WIDTH     = 8,
    parameter int STEP      = 1,
    parameter int LIMIT     = 255,
    parameter int SATURATE  = 0,
    parameter int RESET_VAL = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic             stall,
    input  logic             clr_fault,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_prev,
    output logic             wrap,
    output logic             pend,
    output logic             fault
);

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_BR   = 2'b01;
    localparam logic [1:0] OP_LD   = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    // Increment arithmetic is one bit wider than the PC so the carry is kept.
    localparam logic [WIDTH:0]   STEP_W     = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   LIMIT_W    = (WIDTH+1)'(LIMIT);
    localparam logic [WIDTH:0]   LIMIT_P1_W = (WIDTH+1)'(LIMIT + 1);
    // Branch targets are two bits wider: one for the carry, one for the sign.
    localparam logic [WIDTH+1:0] LIMIT_T    = (WIDTH+2)'(LIMIT);
    localparam logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] LIMIT_PC   = WIDTH'(LIMIT);

    // Target of a branch (pc + signed offset) or load (zero-extended din).
    function automatic logic [WIDTH+1:0] jump_target(
        input logic [1:0]       op_v,
        input logic [WIDTH-1:0] din_v,
        input logic [WIDTH-1:0] pc_v
    );
        logic [WIDTH+1:0] t;
        if (op_v == OP_BR) begin
            t = {2'b00, pc_v} + {{2{din_v[WIDTH-1]}}, din_v};
        end else begin
            t = {2'b00, din_v};
        end
        return t;
    endfunction

    // A target is legal when it is non-negative and not above LIMIT.
    function automatic logic target_legal(input logic [WIDTH+1:0] t);
        return (t[WIDTH+1] == 1'b0) && (t <= LIMIT_T);
    endfunction

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_prev_r;
    logic             wrap_r;
    logic             pend_r;
    logic             fault_r;
    logic [1:0]       pend_op_r;
    logic [WIDTH-1:0] pend_din_r;

    logic [WIDTH:0]   inc_sum_s;
    logic             inc_over_s;
    logic             jump_req_s;
    logic [1:0]       exec_op_s;
    logic [WIDTH-1:0] exec_din_s;
    logic [WIDTH+1:0] target_s;
    logic             target_ok_s;
    logic             fault_set_s;

    logic [WIDTH-1:0] pc_nxt_s;
    logic [WIDTH-1:0] pc_prev_nxt_s;
    logic             wrap_nxt_s;
    logic             pend_nxt_s;
    logic [1:0]       pend_op_nxt_s;
    logic [WIDTH-1:0] pend_din_nxt_s;
    logic             fault_nxt_s;

    // Operand selection and target/increment arithmetic shared by all paths.
    always_comb begin
        inc_sum_s  = {1'b0, pc_r} + STEP_W;
        inc_over_s = (inc_sum_s > LIMIT_W);
        jump_req_s = en && ((op == OP_BR) || (op == OP_LD));
        if (pend_r) begin
            exec_op_s  = pend_op_r;
            exec_din_s = pend_din_r;
        end else begin
            exec_op_s  = op;
            exec_din_s = din;
        end
        target_s    = jump_target(exec_op_s, exec_din_s, pc_r);
        target_ok_s = target_legal(target_s);
    end

    // Next-state decision: stall capture, pending execution, then new request.
    always_comb begin
        pc_nxt_s       = pc_r;
        pc_prev_nxt_s  = pc_prev_r;
        wrap_nxt_s     = 1'b0;
        pend_nxt_s     = pend_r;
        pend_op_nxt_s  = pend_op_r;
        pend_din_nxt_s = pend_din_r;
        fault_set_s    = 1'b0;

        if (stall) begin
            // PC frozen; a branch/load is parked, last request wins.
            if (jump_req_s) begin
                pend_nxt_s     = 1'b1;
                pend_op_nxt_s  = op;
                pend_din_nxt_s = din;
            end else begin
                pend_nxt_s = pend_r;
            end
        end else if (pend_r) begin
            // Parked entry runs first, using the PC as it is now.
            if (target_ok_s) begin
                pc_nxt_s      = target_s[WIDTH-1:0];
                pc_prev_nxt_s = pc_r;
            end else begin
                fault_set_s = 1'b1;
            end
            if (jump_req_s) begin
                pend_nxt_s     = 1'b1;
                pend_op_nxt_s  = op;
                pend_din_nxt_s = din;
            end else begin
                pend_nxt_s = 1'b0;
            end
        end else if (en) begin
            case (op)
                OP_INC: begin
                    pc_prev_nxt_s = pc_r;
                    if (!inc_over_s) begin
                        pc_nxt_s = inc_sum_s[WIDTH-1:0];
                    end else if (SATURATE != 0) begin
                        pc_nxt_s   = LIMIT_PC;
                        wrap_nxt_s = 1'b1;
                    end else begin
                        pc_nxt_s   = WIDTH'(inc_sum_s - LIMIT_P1_W);
                        wrap_nxt_s = 1'b1;
                    end
                end
                OP_BR, OP_LD: begin
                    if (target_ok_s) begin
                        pc_nxt_s      = target_s[WIDTH-1:0];
                        pc_prev_nxt_s = pc_r;
                    end else begin
                        fault_set_s = 1'b1;
                    end
                end
                OP_HOLD: begin
                    pc_nxt_s = pc_r;
                end
                default: begin
                    pc_nxt_s = pc_r;
                end
            endcase
        end else begin
            pc_nxt_s = pc_r;
        end

        // A new fault beats a same-cycle clear.
        if (fault_set_s) begin
            fault_nxt_s = 1'b1;
        end else if (clr_fault) begin
            fault_nxt_s = 1'b0;
        end else begin
            fault_nxt_s = fault_r;
        end
    end

    // State registers with synchronous reset that also drops the pending entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            pc_prev_r  <= RESET_PC;
            wrap_r     <= 1'b0;
            pend_r     <= 1'b0;
            fault_r    <= 1'b0;
            pend_op_r  <= 2'b00;
            pend_din_r <= {WIDTH{1'b0}};
        end else begin
            pc_r       <= pc_nxt_s;
            pc_prev_r  <= pc_prev_nxt_s;
            wrap_r     <= wrap_nxt_s;
            pend_r     <= pend_nxt_s;
            fault_r    <= fault_nxt_s;
            pend_op_r  <= pend_op_nxt_s;
            pend_din_r <= pend_din_nxt_s;
        end
    end

    assign pc      = pc_r;
    assign pc_prev = pc_prev_r;
    assign wrap    = wrap_r;
    assign pend    = pend_r;
    assign fault   = fault_r;

    pc_sequencer_chk #(
        .WIDTH (WIDTH),
        .LIMIT (LIMIT)
    ) u_chk (
        .clock (clock),
        .reset (reset),
        .stall (stall),
        .pc    (pc_r),
        .wrap  (wrap_r),
        .pend  (pend_r)
    );

endmodule

// Invariant checker: PC stays in range, wrap never coexists with a parked
// entry, and a stalled cycle never moves the PC.
module pc_sequencer_chk #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input logic             clock,
    input logic             reset,
    input logic             stall,
    input logic [WIDTH-1:0] pc,
    input logic             wrap,
    input logic             pend
);

    localparam logic [WIDTH-1:0] LIMIT_PC = WIDTH'(LIMIT);

    a_pc_range: assert property (@(posedge clock) disable iff (reset)
        pc <= LIMIT_PC);

    a_wrap_no_pend: assert property (@(posedge clock) disable iff (reset)
        wrap |-> !pend);

    a_stall_freeze: assert property (@(posedge clock) disable iff (reset)
        stall |=> $stable(pc));

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer (default parameters) plus a
// saturating instance exercised by a short hand-written sequence.

module tb_pc_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] din = 8'h00;
    logic       stall = 1'b0;
    logic       clr_fault = 1'b0;

    logic [7:0] pc, pc_prev;
    logic       wrap, pend, fault;
    logic [7:0] pc_s, pc_prev_s;
    logic       wrap_s, pend_s, fault_s;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    pc_sequencer dut (
        .clock(clock), .reset(reset), .en(en), .op(op), .din(din),
        .stall(stall), .clr_fault(clr_fault),
        .pc(pc), .pc_prev(pc_prev), .wrap(wrap), .pend(pend), .fault(fault)
    );

    pc_sequencer #(.SATURATE(1)) dut_sat (
        .clock(clock), .reset(reset), .en(en), .op(op), .din(din),
        .stall(stall), .clr_fault(clr_fault),
        .pc(pc_s), .pc_prev(pc_prev_s), .wrap(wrap_s), .pend(pend_s), .fault(fault_s)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] op;
        logic [7:0] din;
        logic       stall;
        logic       clr;
        logic [7:0] pc;
        logic [7:0] prev;
        logic       wrap;
        logic       pend;
        logic       fault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic [1:0] o,
                       input logic [7:0] d, input logic s, input logic c,
                       input logic [7:0] p, input logic [7:0] pp,
                       input logic w, input logic pn, input logic f);
        vec_t v;
        v.rst = r; v.en = e; v.op = o; v.din = d; v.stall = s; v.clr = c;
        v.pc = p; v.prev = pp; v.wrap = w; v.pend = pn; v.fault = f;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] o,
                        input logic [7:0] d, input logic s, input logic c);
        @(negedge clock);
        reset = r; en = e; op = o; din = d; stall = s; clr_fault = c;
        @(posedge clock);
        #1;
    endtask

    initial begin
        //   rst en op     din    st cl   pc    prev  w  pd f
        add(1'b1,1'b0,2'b00,8'd0,  1'b0,1'b0, 8'd0,  8'd0,  1'b0,1'b0,1'b0); // 0 reset
        add(1'b0,1'b1,2'b00,8'd0,  1'b0,1'b0, 8'd1,  8'd0,  1'b0,1'b0,1'b0); // 1 inc
        add(1'b0,1'b1,2'b00,8'd0,  1'b0,1'b0, 8'd2,  8'd1,  1'b0,1'b0,1'b0);
        add(1'b0,1'b1,2'b00,8'd0,  1'b0,1'b0, 8'd3,  8'd2,  1'b0,1'b0,1'b0);
        add(1'b0,1'b1,2'b10,8'd254,1'b0,1'b0, 8'd254,8'd3,  1'b0,1'b0,1'b0); // 4 load 254
        add(1'b0,1'b1,2'b00,8'd0,  1'b0,1'b0, 8'd255,8'd254,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,2'b00,8'd0,  1'b0,1'b0, 8'd0,  8'd255,1'b1,1'b0,1'b0); // 6 wrap
        add(1'b0,1'b0,2'b00,8'd0,  1'b0,1'b0, 8'd0,  8'd255,1'b0,1'b0,1'b0); // 7 wrap drops
        add(1'b0,1'b1,2'b10,8'd10, 1'b0,1'b0, 8'd10, 8'd0,  1'b0,1'b0,1'b0);
        add(1'b0,1'b1,2'b01,8'hFB, 1'b0,1'b0, 8'd5,  8'd10, 1'b0,1'b0,1'b0); // 9 br -5
        add(1'b0,1'b1,2'b10,8'd3,  1'b0,1'b0, 8'd3,  8'd5,  1'b0,1'b0,1'b0);
        add(1'b0,1'b1,2'b01,8'hFB, 1'b0,1'b0, 8'd3,  8'd5,  1'b0,1'b0,1'b1); // 11 neg fault
        add(1'b0,1'b1,2'b11,8'd77, 1'b0,1'b0, 8'd3,  8'd5,  1'b0,1'b0,1'b1); // 12 hold
        add(1'b0,1'b0,2'b00,8'd0,  1'b0,1'b1, 8'd3,  8'd5,  1'b0,1'b0,1'b0); // 13 clear
        add(1'b0,1'b1,2'b10,8'd20, 1'b0,1'b0, 8'd20, 8'd3,  1'b0,1'b0,1'b0);
        add(1'b0,1'b1,2'b10,8'd100,1'b1,1'b0, 8'd20, 8'd3,  1'b0,1'b1,1'b0); // 15 park
        add(1'b0,1'b1,2'b10,8'd50, 1'b1,1'b0, 8'd20, 8'd3,  1'b0,1'b1,1'b0); // 16 overwrite
        add(1'b0,1'b1,2'b00,8'd0,  1'b0,1'b0, 8'd50, 8'd20, 1'b0,1'b0,1'b0); // 17 exec, inc dropped
        add(1'b0,1'b1,2'b00,8'd0,  1'b0,1'b0, 8'd51, 8'd50, 1'b0,1'b0,1'b0);
        add(1'b0,1'b1,2'b00,8'd0,  1'b1,1'b0, 8'd51, 8'd50, 1'b0,1'b0,1'b0); // 19 stalled inc
        add(1'b0,1'b1,2'b10,8'd7,  1'b1,1'b0, 8'd51, 8'd50, 1'b0,1'b1,1'b0);
        add(1'b1,1'b1,2'b10,8'd9,  1'b1,1'b0, 8'd0,  8'd0,  1'b0,1'b0,1'b0); // 21 reset mid-stall
        add(1'b0,1'b0,2'b00,8'd0,  1'b0,1'b0, 8'd0,  8'd0,  1'b0,1'b0,1'b0); // 22 nothing runs
        add(1'b0,1'b1,2'b10,8'd40, 1'b0,1'b0, 8'd40, 8'd0,  1'b0,1'b0,1'b0);
        add(1'b0,1'b1,2'b01,8'h03, 1'b1,1'b0, 8'd40, 8'd0,  1'b0,1'b1,1'b0); // 24 park br +3
        add(1'b0,1'b0,2'b00,8'd0,  1'b0,1'b0, 8'd43, 8'd40, 1'b0,1'b0,1'b0);
        add(1'b0,1'b1,2'b10,8'd250,1'b0,1'b0, 8'd250,8'd43, 1'b0,1'b0,1'b0);
        add(1'b0,1'b1,2'b01,8'h0A, 1'b0,1'b0, 8'd250,8'd43, 1'b0,1'b0,1'b1); // 27 over fault
        add(1'b0,1'b1,2'b01,8'h0A, 1'b0,1'b1, 8'd250,8'd43, 1'b0,1'b0,1'b1); // 28 fault beats clr
        add(1'b0,1'b0,2'b00,8'd0,  1'b0,1'b1, 8'd250,8'd43, 1'b0,1'b0,1'b0);
        add(1'b0,1'b1,2'b10,8'd9,  1'b1,1'b0, 8'd250,8'd43, 1'b0,1'b1,1'b0);
        add(1'b0,1'b1,2'b10,8'd77, 1'b0,1'b0, 8'd9,  8'd250,1'b0,1'b1,1'b0); // 31 exec + recapture
        add(1'b0,1'b0,2'b00,8'd0,  1'b0,1'b0, 8'd77, 8'd9,  1'b0,1'b0,1'b0);
        add(1'b0,1'b1,2'b01,8'h80, 1'b1,1'b0, 8'd77, 8'd9,  1'b0,1'b1,1'b0);
        add(1'b0,1'b0,2'b00,8'd0,  1'b0,1'b0, 8'd77, 8'd9,  1'b0,1'b0,1'b1); // 34 parked fault
        add(1'b0,1'b0,2'b00,8'd0,  1'b0,1'b1, 8'd77, 8'd9,  1'b0,1'b0,1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].din,
                 vecs[i].stall, vecs[i].clr);
            check("pc",      i, pc,             vecs[i].pc);
            check("pc_prev", i, pc_prev,        vecs[i].prev);
            check("wrap",    i, {7'd0, wrap},   {7'd0, vecs[i].wrap});
            check("pend",    i, {7'd0, pend},   {7'd0, vecs[i].pend});
            check("fault",   i, {7'd0, fault},  {7'd0, vecs[i].fault});
        end

        // Saturating instance: increment at LIMIT holds and pulses wrap.
        step(1'b1, 1'b0, 2'b00, 8'd0,   1'b0, 1'b0);
        check("sat_reset_pc", 100, pc_s, 8'd0);
        step(1'b0, 1'b1, 2'b10, 8'd255, 1'b0, 1'b0);
        check("sat_load_pc", 101, pc_s, 8'd255);
        check("sat_load_wrap", 101, {7'd0, wrap_s}, 8'd0);
        step(1'b0, 1'b1, 2'b00, 8'd0,   1'b0, 1'b0);
        check("sat_inc_pc",   102, pc_s,      8'd255);
        check("sat_inc_prev", 102, pc_prev_s, 8'd255);
        check("sat_inc_wrap", 102, {7'd0, wrap_s}, 8'd1);
        check("wrap_inc_pc",  102, pc,        8'd0);
        check("wrap_inc_flag",102, {7'd0, wrap}, 8'd1);
        step(1'b0, 1'b0, 2'b00, 8'd0,   1'b0, 1'b0);
        check("sat_idle_wrap", 103, {7'd0, wrap_s}, 8'd0);
        check("sat_idle_pc",   103, pc_s, 8'd255);
        step(1'b0, 1'b1, 2'b00, 8'd0,   1'b1, 1'b0);
        check("sat_stall_wrap", 104, {7'd0, wrap_s}, 8'd0);
        step(1'b0, 1'b1, 2'b00, 8'd0,   1'b0, 1'b0);
        check("sat_again_wrap", 105, {7'd0, wrap_s}, 8'd1);
        check("sat_again_pc",   105, pc_s, 8'd255);
        check("sat_fault",      105, {7'd0, fault_s}, 8'd0);
        check("sat_pend",       105, {7'd0, pend_s}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
